// File: rtl/fp_add_rs_scheduler_if.sv
// Bundle of the dispatch, CDB snoop, FPA and result handshake signals
// shared between the add reservation-station scheduler and its neighbours.
// The scheduler connects through the slave modport; the surrounding core
// (dispatch unit, CDB, FPA datapath, CDB arbiter) uses the master modport.
interface fp_add_rs_scheduler_if #(
    parameter int NUM_RS = 4,
    parameter int TAG_W  = 3
);
    localparam int CNT_W = $clog2(NUM_RS + 1);

    logic             disp_valid;
    logic             disp_ready;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic             disp_rj;
    logic             disp_rk;
    logic [TAG_W-1:0] disp_qj;
    logic [TAG_W-1:0] disp_qk;
    logic [TAG_W-1:0] disp_dest;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic [31:0]      fpa_a;
    logic [31:0]      fpa_b;
    logic [31:0]      fpa_out;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;
    logic             res_grant;

    logic [CNT_W-1:0] busy_count;

    modport slave (
        input  disp_valid, disp_vj, disp_vk, disp_rj, disp_rk,
               disp_qj, disp_qk, disp_dest,
               cdb_valid, cdb_tag, cdb_data,
               fpa_out, res_grant,
        output disp_ready, fpa_a, fpa_b,
               res_valid, res_tag, res_data, busy_count
    );

    modport master (
        output disp_valid, disp_vj, disp_vk, disp_rj, disp_rk,
               disp_qj, disp_qk, disp_dest,
               cdb_valid, cdb_tag, cdb_data,
               fpa_out, res_grant,
        input  disp_ready, fpa_a, fpa_b,
               res_valid, res_tag, res_data, busy_count
    );
endinterface

// File: rtl/fp_add_rs_scheduler.sv
// Reservation-station scheduler for the single shared FP adder.
// Holds up to NUM_RS pending adds, snoops the CDB for missing operands,
// issues ready entries round-robin to the FPA, and holds each result until
// the CDB arbiter grants it.
// Optional macro FPA_RS_BACK_TO_BACK_EN: when defined, a granted result in
// HOLD may be followed by a new issue on the same edge (no idle bubble).
module fp_add_rs_scheduler #(
    parameter int NUM_RS   = 4,
    parameter int TAG_W    = 3,
    parameter int EXEC_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_add_rs_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = $clog2(NUM_RS + 1);
    localparam int LAT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(EXEC_LAT - 1);
    localparam logic [IDX_W:0]   NUM_RS_W  = (IDX_W + 1)'(NUM_RS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Entry storage
    logic [NUM_RS-1:0] busy_q;
    logic [NUM_RS-1:0] rj_q;
    logic [NUM_RS-1:0] rk_q;
    logic [31:0]       vj_q   [NUM_RS];
    logic [31:0]       vk_q   [NUM_RS];
    logic [TAG_W-1:0]  qj_q   [NUM_RS];
    logic [TAG_W-1:0]  qk_q   [NUM_RS];
    logic [TAG_W-1:0]  dest_q [NUM_RS];

    // Issue pipeline / result state
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fpa_a_q, fpa_a_d;
    logic [31:0]      fpa_b_q, fpa_b_d;
    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]      res_data_q, res_data_d;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic [NUM_RS-1:0] ready_vec;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              disp_fire;
    logic              issue_fire;
    logic              disp_j_hit;
    logic              disp_k_hit;
    logic [CNT_W-1:0]  busy_count_w;

    assign ready_vec  = busy_q & rj_q & rk_q;
    assign disp_fire  = bus.disp_valid & free_found;
    assign disp_j_hit = !bus.disp_rj && bus.cdb_valid && (bus.disp_qj == bus.cdb_tag);
    assign disp_k_hit = !bus.disp_rk && bus.cdb_valid && (bus.disp_qk == bus.cdb_tag);

    // Lowest-index free entry; scanning downward leaves the lowest one last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // First ready entry at or after the round-robin pointer, wrapping around.
    always_comb begin
        logic [IDX_W:0] sum;
        sum       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 0; off < NUM_RS; off++) begin
            sum = {1'b0, rr_q} + (IDX_W + 1)'(off);
            if (sum >= NUM_RS_W) begin
                sum = sum - NUM_RS_W;
            end
            if (!sel_found && ready_vec[sum[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sum[IDX_W-1:0];
            end
        end
    end

    // Issue happens from IDLE, or straight out of a granted HOLD when enabled.
    always_comb begin
        issue_fire = 1'b0;
        case (state_q)
            ST_IDLE: issue_fire = sel_found;
`ifdef FPA_RS_BACK_TO_BACK_EN
            ST_HOLD: issue_fire = sel_found && bus.res_grant;
`else
            ST_HOLD: issue_fire = 1'b0;
`endif
            default: issue_fire = 1'b0;
        endcase
    end

    // FSM next state: count down execution latency, capture and hold result.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        fpa_a_d     = fpa_a_q;
        fpa_b_d     = fpa_b_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    res_data_d  = bus.fpa_out;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.res_grant) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (issue_fire) begin
            fpa_a_d   = vj_q[sel_idx];
            fpa_b_d   = vk_q[sel_idx];
            res_tag_d = dest_q[sel_idx];
            rr_d      = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
            cnt_d     = LAT_LOAD;
            state_d   = ST_EXEC;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            fpa_a_q     <= '0;
            fpa_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            fpa_a_q     <= fpa_a_d;
            fpa_b_q     <= fpa_b_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
        end
    end

    // Occupancy: dispatch claims the free slot, issue releases the selected one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (disp_fire && (free_idx == IDX_W'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (issue_fire && (sel_idx == IDX_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Entry payload: dispatch write with CDB bypass, else snoop the CDB.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RS; i++) begin
            if (disp_fire && (free_idx == IDX_W'(i))) begin
                vj_q[i]   <= disp_j_hit ? bus.cdb_data : bus.disp_vj;
                vk_q[i]   <= disp_k_hit ? bus.cdb_data : bus.disp_vk;
                rj_q[i]   <= bus.disp_rj | disp_j_hit;
                rk_q[i]   <= bus.disp_rk | disp_k_hit;
                qj_q[i]   <= bus.disp_qj;
                qk_q[i]   <= bus.disp_qk;
                dest_q[i] <= bus.disp_dest;
            end else if (busy_q[i]) begin
                if (!rj_q[i] && bus.cdb_valid && (qj_q[i] == bus.cdb_tag)) begin
                    vj_q[i] <= bus.cdb_data;
                    rj_q[i] <= 1'b1;
                end
                if (!rk_q[i] && bus.cdb_valid && (qk_q[i] == bus.cdb_tag)) begin
                    vk_q[i] <= bus.cdb_data;
                    rk_q[i] <= 1'b1;
                end
            end
        end
    end

    // Population count of busy entries.
    always_comb begin
        busy_count_w = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            busy_count_w = busy_count_w + CNT_W'(busy_q[i]);
        end
    end

    assign bus.disp_ready = free_found;
    assign bus.fpa_a      = fpa_a_q;
    assign bus.fpa_b      = fpa_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.res_data   = res_data_q;
    assign bus.busy_count = busy_count_w;
endmodule

// File: tb/tb_fp_add_rs_scheduler.sv
// Self-checking bench for fp_add_rs_scheduler: table of single-add vectors,
// directed multi-cycle sequences (snoop, bypass, full RS, round-robin order,
// long hold, reset mid-execution) and a randomized phase checked against a
// tag-keyed scoreboard of outstanding adds. A behavioural stand-in for the
// FPA is built from real arithmetic.
module tb_fp_add_rs_scheduler;
    localparam int NUM_RS   = 4;
    localparam int TAG_W    = 3;
    localparam int EXEC_LAT = 2;
    localparam int NTAGS    = 2 ** TAG_W;

    logic clk = 1'b0;
    logic rst;

    int passCount  = 0;
    int checkCount = 0;

    fp_add_rs_scheduler_if #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) bus ();

    fp_add_rs_scheduler #(
        .NUM_RS  (NUM_RS),
        .TAG_W   (TAG_W),
        .EXEC_LAT(EXEC_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic real toReal(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] fromReal(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Integer-valued operands keep every sum exact in single precision.
    function automatic logic [31:0] randVal();
        real r;
        r = real'($urandom_range(0, 1000));
        if ($urandom_range(0, 1) == 1) r = -r;
        return fromReal(r);
    endfunction

    // Behavioural FPA: purely combinational sum of the issued operands.
    always_comb bus.fpa_out = fromReal(toReal(bus.fpa_a) + toReal(bus.fpa_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checkCount++;
        if (actual >= lo && actual <= hi) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic rj, input logic rk,
                                 input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                                 input logic [TAG_W-1:0] dest);
        bus.disp_valid = v;
        bus.disp_vj    = vj;
        bus.disp_vk    = vk;
        bus.disp_rj    = rj;
        bus.disp_rk    = rk;
        bus.disp_qj    = qj;
        bus.disp_qk    = qk;
        bus.disp_dest  = dest;
    endtask

    task automatic applyCdb(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyCdb(1'b0, '0, '0);
        bus.res_grant = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, then grant it.
    task automatic waitResult(input string name, input logic [TAG_W-1:0] expTag,
                              input logic [31:0] expData);
        int n;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({name, "_valid"}, 32'(bus.res_valid), 32'd1);
        checkOutput({name, "_tag"}, 32'(bus.res_tag), 32'(expTag));
        checkOutput({name, "_data"}, bus.res_data, expData);
        bus.res_grant = 1'b1;
        tick();
        bus.res_grant = 1'b0;
        checkOutput({name, "_released"}, 32'(bus.res_valid), 32'd0);
    endtask

    // Scoreboard of outstanding adds keyed by destination tag.
    logic        sbValid [NTAGS];
    logic        sbRj    [NTAGS];
    logic        sbRk    [NTAGS];
    logic [TAG_W-1:0] sbQj [NTAGS];
    logic [TAG_W-1:0] sbQk [NTAGS];
    logic [31:0] sbVj    [NTAGS];
    logic [31:0] sbVk    [NTAGS];

    function automatic int sbTotal();
        int c = 0;
        for (int t = 0; t < NTAGS; t++) if (sbValid[t]) c++;
        return c;
    endfunction

    function automatic int sbUnresolved();
        int c = 0;
        for (int t = 0; t < NTAGS; t++) if (sbValid[t] && !(sbRj[t] && sbRk[t])) c++;
        return c;
    endfunction

    // One cycle of randomized traffic, with the scoreboard following along.
    task automatic modelCycle(input logic dV, input logic [TAG_W-1:0] dDest,
                              input logic dRj, input logic dRk,
                              input logic [TAG_W-1:0] dQj, input logic [TAG_W-1:0] dQk,
                              input logic [31:0] dVj, input logic [31:0] dVk,
                              input logic cV, input logic [TAG_W-1:0] cTag,
                              input logic [31:0] cData, input logic gnt);
        logic fire, took;
        logic [TAG_W-1:0] tTag;
        logic [31:0] tData;
        applyStimulus(dV, dVj, dVk, dRj, dRk, dQj, dQk, dDest);
        applyCdb(cV, cTag, cData);
        bus.res_grant = gnt;
        fire  = dV && bus.disp_ready;
        took  = gnt && bus.res_valid;
        tTag  = bus.res_tag;
        tData = bus.res_data;
        tick();
        if (took) begin
            checkOutput("rand_tag_known", 32'(sbValid[tTag]), 32'd1);
            if (sbValid[tTag]) begin
                checkOutput("rand_operands_ready", 32'(sbRj[tTag] && sbRk[tTag]), 32'd1);
                checkOutput("rand_data", tData, fromReal(toReal(sbVj[tTag]) + toReal(sbVk[tTag])));
                sbValid[tTag] = 1'b0;
            end
        end
        if (cV) begin
            for (int t = 0; t < NTAGS; t++) begin
                if (sbValid[t] && !sbRj[t] && sbQj[t] == cTag) begin
                    sbRj[t] = 1'b1;
                    sbVj[t] = cData;
                end
                if (sbValid[t] && !sbRk[t] && sbQk[t] == cTag) begin
                    sbRk[t] = 1'b1;
                    sbVk[t] = cData;
                end
            end
        end
        if (fire) begin
            sbValid[dDest] = 1'b1;
            sbQj[dDest]    = dQj;
            sbQk[dDest]    = dQk;
            sbRj[dDest]    = dRj || (cV && dQj == cTag);
            sbRk[dDest]    = dRk || (cV && dQk == cTag);
            sbVj[dDest]    = dRj ? dVj : cData;
            sbVk[dDest]    = dRk ? dVk : cData;
        end
        checkRange("rand_busy_count", int'(bus.busy_count), sbUnresolved(), sbTotal());
    endtask

    typedef struct {
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] dest;
        logic [31:0]      expSum;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n, gapExp, highs, start;
        logic [TAG_W-1:0] dest;
        logic dV;

        vecs[0] = '{32'h42DC0000, 32'h41900000, 3'd5, 32'h43000000};
        vecs[1] = '{32'h3F800000, 32'h40000000, 3'd1, 32'h40400000};
        vecs[2] = '{32'h40A00000, 32'h40A00000, 3'd3, 32'h41200000};
        vecs[3] = '{32'h00000000, 32'h41200000, 3'd7, 32'h41200000};
        vecs[4] = '{32'hC0400000, 32'h40400000, 3'd0, 32'h00000000};
        vecs[5] = '{32'h3FC00000, 32'h3FC00000, 3'd6, 32'h40400000};

        // Reset state
        doReset();
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_res_tag", 32'(bus.res_tag), 32'd0);
        checkOutput("rst_res_data", bus.res_data, 32'd0);
        checkOutput("rst_fpa_a", bus.fpa_a, 32'd0);
        checkOutput("rst_fpa_b", bus.fpa_b, 32'd0);
        checkOutput("rst_busy_count", 32'(bus.busy_count), 32'd0);
        checkOutput("rst_disp_ready", 32'(bus.disp_ready), 32'd1);

        // Table: single ready add, exact issue-to-result latency and hold
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b1, vecs[v].vj, vecs[v].vk, 1'b1, 1'b1, '0, '0, vecs[v].dest);
            tick();
            idleInputs();
            checkOutput("vec_busy_after_dispatch", 32'(bus.busy_count), 32'd1);
            tick();
            checkOutput("vec_fpa_a", bus.fpa_a, vecs[v].vj);
            checkOutput("vec_fpa_b", bus.fpa_b, vecs[v].vk);
            repeat (EXEC_LAT - 1) tick();
            checkOutput("vec_res_not_early", 32'(bus.res_valid), 32'd0);
            tick();
            checkOutput("vec_res_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("vec_res_tag", 32'(bus.res_tag), 32'(vecs[v].dest));
            checkOutput("vec_res_data", bus.res_data, vecs[v].expSum);
            tick();
            tick();
            checkOutput("vec_res_held", 32'(bus.res_valid), 32'd1);
            bus.res_grant = 1'b1;
            tick();
            bus.res_grant = 1'b0;
            checkOutput("vec_res_released", 32'(bus.res_valid), 32'd0);
        end

        // Operand j arrives later over the CDB
        applyStimulus(1'b1, 32'h0, 32'h40000000, 1'b0, 1'b1, 3'd2, '0, 3'd1);
        tick();
        idleInputs();
        checkOutput("t2_busy_waiting", 32'(bus.busy_count), 32'd1);
        applyCdb(1'b1, 3'd2, 32'h3F800000);
        tick();
        applyCdb(1'b0, '0, '0);
        checkOutput("t2_no_issue_on_snoop_edge", 32'(bus.busy_count), 32'd1);
        tick();
        checkOutput("t2_issued", 32'(bus.busy_count), 32'd0);
        checkOutput("t2_fpa_a", bus.fpa_a, 32'h3F800000);
        checkOutput("t2_fpa_b", bus.fpa_b, 32'h40000000);
        waitResult("t2", 3'd1, 32'h40400000);

        // Both operands bypassed from a same-cycle broadcast
        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'd3, 3'd3, 3'd2);
        applyCdb(1'b1, 3'd3, 32'h40A00000);
        tick();
        idleInputs();
        waitResult("t4", 3'd2, 32'h41200000);

        // Fill every entry, reject the extra dispatch, free one slot
        doReset();
        for (int i = 0; i < NUM_RS; i++) begin
            applyStimulus(1'b1, 32'h0, 32'h3F800000, 1'b0, 1'b1,
                          (i == 0) ? 3'd6 : 3'd7, '0, 3'(i));
            tick();
        end
        checkOutput("t3_busy_full", 32'(bus.busy_count), 32'd4);
        checkOutput("t3_ready_low", 32'(bus.disp_ready), 32'd0);
        applyStimulus(1'b1, 32'h40000000, 32'h40000000, 1'b1, 1'b1, '0, '0, 3'd4);
        tick();
        idleInputs();
        checkOutput("t3_fifth_ignored", 32'(bus.busy_count), 32'd4);
        applyCdb(1'b1, 3'd6, 32'h40000000);
        tick();
        applyCdb(1'b0, '0, '0);
        checkOutput("t3_freed_not_yet", 32'(bus.disp_ready), 32'd0);
        tick();
        checkOutput("t3_busy_after_issue", 32'(bus.busy_count), 32'd3);
        checkOutput("t3_ready_again", 32'(bus.disp_ready), 32'd1);
        waitResult("t3_e0", 3'd0, 32'h40400000);
        applyCdb(1'b1, 3'd7, 32'h40800000);
        tick();
        applyCdb(1'b0, '0, '0);
        waitResult("t3_e1", 3'd1, 32'h40A00000);
        waitResult("t3_e2", 3'd2, 32'h40A00000);
        waitResult("t3_e3", 3'd3, 32'h40A00000);

        // Round-robin: pointer at 1, entries 0..2 ready together
        doReset();
        applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1, '0, '0, 3'd7);
        tick();
        idleInputs();
        waitResult("t5_prime", 3'd7, 32'h40000000);
        applyStimulus(1'b1, 32'h0, 32'h3F800000, 1'b0, 1'b1, 3'd4, '0, 3'd0);
        tick();
        applyStimulus(1'b1, 32'h0, 32'h40000000, 1'b0, 1'b1, 3'd4, '0, 3'd1);
        tick();
        applyStimulus(1'b1, 32'h0, 32'h40400000, 1'b0, 1'b1, 3'd4, '0, 3'd2);
        tick();
        idleInputs();
        applyCdb(1'b1, 3'd4, 32'h41000000);
        tick();
        applyCdb(1'b0, '0, '0);
        waitResult("t5_first", 3'd1, 32'h41200000);
        waitResult("t5_second", 3'd2, 32'h41300000);
        waitResult("t5_third", 3'd0, 32'h41100000);

        // Long hold without grant, then gap to next result, then reset mid-EXEC
        doReset();
        applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b1, '0, '0, 3'd4);
        tick();
        idleInputs();
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        applyStimulus(1'b1, 32'h40400000, 32'h40800000, 1'b1, 1'b1, '0, '0, 3'd6);
        tick();
        idleInputs();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t6_hold_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("t6_hold_tag", 32'(bus.res_tag), 32'd4);
            checkOutput("t6_hold_data", bus.res_data, 32'h40400000);
            checkOutput("t6_hold_no_issue", 32'(bus.busy_count), 32'd1);
            tick();
        end
        bus.res_grant = 1'b1;
        tick();
        bus.res_grant = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
`ifdef FPA_RS_BACK_TO_BACK_EN
        gapExp = EXEC_LAT;
`else
        gapExp = EXEC_LAT + 1;
`endif
        checkOutput("t6_grant_to_next_result", 32'(n), 32'(gapExp));
        waitResult("t6_second", 3'd6, 32'h40E00000);
        applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1, '0, '0, 3'd2);
        tick();
        applyStimulus(1'b1, 32'h40000000, 32'h40000000, 1'b1, 1'b1, '0, '0, 3'd3);
        tick();
        idleInputs();
        checkOutput("t6_pre_rst_fpa_a", bus.fpa_a, 32'h3F800000);
        checkOutput("t6_pre_rst_busy", 32'(bus.busy_count), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("t6_rst_busy", 32'(bus.busy_count), 32'd0);
        checkOutput("t6_rst_fpa_a", bus.fpa_a, 32'd0);
        checkOutput("t6_rst_fpa_b", bus.fpa_b, 32'd0);
        tick();
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.res_valid) highs++;
        end
        checkOutput("t6_no_result_after_rst", 32'(highs), 32'd0);

        // Randomized traffic against the scoreboard
        doReset();
        for (int t = 0; t < NTAGS; t++) sbValid[t] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            dV = ($urandom_range(0, 99) < 50);
            start = $urandom_range(0, NTAGS - 1);
            dest = '0;
            n = 0;
            for (int k = 0; k < NTAGS; k++) begin
                if (n == 0 && !sbValid[(start + k) % NTAGS]) begin
                    dest = TAG_W'((start + k) % NTAGS);
                    n = 1;
                end
            end
            if (n == 0) dV = 1'b0;
            modelCycle(dV, dest, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       TAG_W'($urandom_range(0, NTAGS - 1)), TAG_W'($urandom_range(0, NTAGS - 1)),
                       randVal(), randVal(),
                       ($urandom_range(0, 99) < 30), TAG_W'($urandom_range(0, NTAGS - 1)),
                       randVal(), ($urandom_range(0, 99) < 40));
        end
        for (int cyc = 0; cyc < 300 && sbTotal() > 0; cyc++) begin
            modelCycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0,
                       1'b1, TAG_W'(cyc % NTAGS), randVal(), 1'b1);
        end
        idleInputs();
        checkOutput("drain_scoreboard_empty", 32'(sbTotal()), 32'd0);
        tick();
        tick();
        checkOutput("drain_busy_count", 32'(bus.busy_count), 32'd0);
        checkOutput("drain_res_valid", 32'(bus.res_valid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
